// File: rtl/lbus_poly_if.sv
// ---------------------------------------------------------------------------
// lbus_poly_if
//
// Local-bus slave in front of the polynomial core. The host performs
// two-cycle transfers: an address cycle (lbus_wrn=1) followed by a data
// cycle (lbus_wrn=0). In the data cycle, lbus_rdn=1 commits a write and
// lbus_rdn=0 performs a read. Writes land in a register file of NWORD
// 32-bit coefficient words, accessed as 16-bit halves. Reads return
// control/status, coefficients or core results.
//
// Ports
//   clk        in   bus clock, everything on the rising edge
//   rst        in   synchronous active-high reset
//   lbus_di_a  in   16-bit address (address cycle) / data (data cycle)
//   lbus_wrn   in   1 = address cycle
//   lbus_rdn   in   0 in a data cycle = read request
//   lbus_do    out  registered read data
//   coef_o     out  NWORD packed coefficient words (word k at [32k+31:32k])
//   start_o    out  one-cycle start pulse to the core
//   busy_i     in   core busy
//   done_i     in   one-cycle completion pulse from the core
//   res_i      in   NWORD packed result words, same packing as coef_o
//
// State table
//   state  | meaning
//   S_IDLE | no address latched; data cycles are ignored
//   S_ADDR | address latched; next non-address cycle is the data cycle
// ---------------------------------------------------------------------------
module lbus_poly_if #(
    parameter int          NWORD          = 7,
    parameter logic [15:0] ADDR_CTRL      = 16'h0002,
    parameter logic [15:0] ADDR_COEF      = 16'h0100,
    parameter logic [15:0] ADDR_COEF_LAST = 16'h0110,
    parameter logic [15:0] ADDR_RES       = 16'h0180
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           lbus_di_a,
    input  logic                  lbus_wrn,
    input  logic                  lbus_rdn,
    output logic [15:0]           lbus_do,
    output logic [32*NWORD-1:0]   coef_o,
    output logic                  start_o,
    input  logic                  busy_i,
    input  logic                  done_i,
    input  logic [32*NWORD-1:0]   res_i
);

    localparam int IW = (NWORD > 1) ? $clog2(NWORD) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ADDR = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [15:0]   r_addr;
    logic [15:0]   r_do;
    logic          r_start;
    logic          r_done_flag;
    logic [31:0]   r_coef [NWORD];

    logic [31:0]   w_res [NWORD];

    logic          w_wr_commit;
    logic          w_rd_commit;

    logic          w_ctrl_hit;
    logic          w_coef_hit;
    logic [IW-1:0] w_coef_idx;
    logic          w_coef_hi;
    logic          w_res_hit;
    logic [IW-1:0] w_res_idx;
    logic          w_res_hi;

    logic          w_ctrl_wr;
    logic          w_start_acc;
    logic          w_clear;
    logic [15:0]   w_rd_data;

    for (genvar g = 0; g < NWORD; g++) begin : g_pack
        assign w_res[g]             = res_i[32*g +: 32];
        assign coef_o[32*g +: 32]   = r_coef[g];
    end

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state. An address cycle always (re)enters S_ADDR, so a
    // second consecutive address cycle simply replaces the first.
    // ---------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (lbus_wrn) begin
            w_state_nxt = S_ADDR;
        end else if (r_state == S_ADDR) begin
            w_state_nxt = S_IDLE;
        end
    end

    // ---------------------------------------------------------------
    // FSM: outputs (commit strobes). Read wins over write.
    // ---------------------------------------------------------------
    always_comb begin
        w_wr_commit = 1'b0;
        w_rd_commit = 1'b0;
        if (r_state == S_ADDR && !lbus_wrn) begin
            if (!lbus_rdn) begin
                w_rd_commit = 1'b1;
            end else begin
                w_wr_commit = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Address decode on the latched address, full 16-bit compare.
    // Coefficient words 0..NWORD-2 are contiguous from ADDR_COEF; the
    // last word sits on its own at ADDR_COEF_LAST.
    // ---------------------------------------------------------------
    always_comb begin
        w_ctrl_hit = (r_addr == ADDR_CTRL);
        w_coef_hit = 1'b0;
        w_coef_idx = '0;
        w_coef_hi  = 1'b0;
        w_res_hit  = 1'b0;
        w_res_idx  = '0;
        w_res_hi   = 1'b0;

        for (int k = 0; k < NWORD - 1; k++) begin
            if (r_addr == ADDR_COEF + 16'(2*k)) begin
                w_coef_hit = 1'b1;
                w_coef_idx = IW'(k);
                w_coef_hi  = 1'b0;
            end
            if (r_addr == ADDR_COEF + 16'(2*k + 1)) begin
                w_coef_hit = 1'b1;
                w_coef_idx = IW'(k);
                w_coef_hi  = 1'b1;
            end
        end
        if (r_addr == ADDR_COEF_LAST) begin
            w_coef_hit = 1'b1;
            w_coef_idx = IW'(NWORD - 1);
            w_coef_hi  = 1'b0;
        end
        if (r_addr == ADDR_COEF_LAST + 16'd1) begin
            w_coef_hit = 1'b1;
            w_coef_idx = IW'(NWORD - 1);
            w_coef_hi  = 1'b1;
        end

        for (int k = 0; k < NWORD; k++) begin
            if (r_addr == ADDR_RES + 16'(2*k)) begin
                w_res_hit = 1'b1;
                w_res_idx = IW'(k);
                w_res_hi  = 1'b0;
            end
            if (r_addr == ADDR_RES + 16'(2*k + 1)) begin
                w_res_hit = 1'b1;
                w_res_idx = IW'(k);
                w_res_hi  = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Control write decode. A start is only accepted while the core is
    // idle; a busy core silently drops it.
    // ---------------------------------------------------------------
    always_comb begin
        w_ctrl_wr   = w_wr_commit && w_ctrl_hit;
        w_start_acc = w_ctrl_wr && lbus_di_a[0] && !busy_i;
        w_clear     = w_ctrl_wr && lbus_di_a[2];
    end

    // ---------------------------------------------------------------
    // Read mux
    // ---------------------------------------------------------------
    always_comb begin
        w_rd_data = 16'h0000;
        if (w_ctrl_hit) begin
            w_rd_data = {14'b0, r_done_flag, busy_i};
        end else if (w_coef_hit) begin
            w_rd_data = w_coef_hi ? r_coef[w_coef_idx][31:16]
                                  : r_coef[w_coef_idx][15:0];
        end else if (w_res_hit) begin
            w_rd_data = w_res_hi ? w_res[w_res_idx][31:16]
                                 : w_res[w_res_idx][15:0];
        end
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= 16'h0000;
            r_do        <= 16'h0000;
            r_start     <= 1'b0;
            r_done_flag <= 1'b0;
            for (int k = 0; k < NWORD; k++) begin
                r_coef[k] <= 32'h0;
            end
        end else begin
            if (lbus_wrn) begin
                r_addr <= lbus_di_a;
            end

            if (w_rd_commit) begin
                r_do <= w_rd_data;
            end

            // Data cycles are at least two cycles apart, so this can
            // never produce a pulse two cycles in a row.
            r_start <= w_start_acc;

            // done_i has priority over the clear from an accepted start.
            if (done_i) begin
                r_done_flag <= 1'b1;
            end else if (w_start_acc) begin
                r_done_flag <= 1'b0;
            end

            if (w_clear) begin
                for (int k = 0; k < NWORD; k++) begin
                    r_coef[k] <= 32'h0;
                end
            end else if (w_wr_commit && w_coef_hit) begin
                if (w_coef_hi) begin
                    r_coef[w_coef_idx][31:16] <= lbus_di_a;
                end else begin
                    r_coef[w_coef_idx][15:0]  <= lbus_di_a;
                end
            end
        end
    end

    assign lbus_do = r_do;
    assign start_o = r_start;

endmodule

// File: tb/tb_lbus_poly_if.sv
module tb_lbus_poly_if;

    localparam int NWORD = 7;
    localparam int K_READ  = 0;
    localparam int K_START = 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [15:0]          lbus_di_a;
    logic                 lbus_wrn;
    logic                 lbus_rdn;
    logic [15:0]          lbus_do;
    logic [32*NWORD-1:0]  coef_o;
    logic                 start_o;
    logic                 busy_i;
    logic                 done_i;
    logic [32*NWORD-1:0]  res_i;

    int checks   = 0;
    int failures = 0;

    int          q_kind [$];
    logic [15:0] q_val  [$];
    string       q_name [$];

    int exp_starts = 0;
    int seen_starts = 0;

    logic [31:0] exp_coef [NWORD];

    logic mon_prev_addr = 1'b0;
    logic mon_rd_now    = 1'b0;
    logic mon_wr_now    = 1'b0;
    logic mon_last_start = 1'b0;

    lbus_poly_if dut (
        .clk       (clk),
        .rst       (rst),
        .lbus_di_a (lbus_di_a),
        .lbus_wrn  (lbus_wrn),
        .lbus_rdn  (lbus_rdn),
        .lbus_do   (lbus_do),
        .coef_o    (coef_o),
        .start_o   (start_o),
        .busy_i    (busy_i),
        .done_i    (done_i),
        .res_i     (res_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: follows the bus protocol to know when lbus_do becomes valid
    // and pops the scoreboard; every start pulse also pops an entry.
    always @(posedge clk) begin
        mon_rd_now    = mon_prev_addr && !lbus_wrn && !lbus_rdn && !rst;
        mon_wr_now    = mon_prev_addr && !lbus_wrn &&  lbus_rdn && !rst;
        mon_prev_addr = lbus_wrn && !rst;
        #1;
        if (mon_rd_now) begin
            checks++;
            if (q_kind.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read: got lbus_do=%h with no expectation queued", lbus_do);
            end else begin
                if (q_kind[0] != K_READ || lbus_do !== q_val[0]) begin
                    failures++;
                    $display("FAIL %s: lbus_do=%h kind=%0d, required %h kind=%0d",
                             q_name[0], lbus_do, K_READ, q_val[0], q_kind[0]);
                end
                void'(q_kind.pop_front());
                void'(q_val.pop_front());
                void'(q_name.pop_front());
            end
        end
        if (start_o === 1'b1) begin
            seen_starts++;
            checks++;
            if (q_kind.size() == 0) begin
                failures++;
                $display("FAIL unexpected_start: start_o=1 with no expectation queued");
            end else begin
                if (q_kind[0] != K_START || !mon_wr_now || mon_last_start) begin
                    failures++;
                    $display("FAIL %s: start_o=1 kind=%0d on_write_edge=%0b prev_start=%0b, required kind=%0d on_write_edge=1 prev_start=0",
                             q_name[0], K_START, mon_wr_now, mon_last_start, q_kind[0]);
                end
                void'(q_kind.pop_front());
                void'(q_val.pop_front());
                void'(q_name.pop_front());
            end
        end
        mon_last_start = start_o;
    end

    task automatic cyc(input logic wrn, input logic rdn, input logic [15:0] d, input logic dn);
        @(negedge clk);
        lbus_wrn  = wrn;
        lbus_rdn  = rdn;
        lbus_di_a = d;
        done_i    = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cyc(1'b1, 1'b1, a, 1'b0);
        cyc(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string nm);
        q_kind.push_back(K_READ);
        q_val.push_back(e);
        q_name.push_back(nm);
        cyc(1'b1, 1'b1, a, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    task automatic push_start(input string nm);
        q_kind.push_back(K_START);
        q_val.push_back(16'h0000);
        q_name.push_back(nm);
        exp_starts++;
    endtask

    task automatic chk_coef(input string nm);
        logic [32*NWORD-1:0] v;
        for (int k = 0; k < NWORD; k++) v[32*k +: 32] = exp_coef[k];
        checks++;
        if (coef_o !== v) begin
            failures++;
            $display("FAIL %s: coef_o=%h, required %h", nm, coef_o, v);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] e);
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s: got %h, required %h", nm, act, e);
        end
    endtask

    initial begin
        logic [15:0] base;
        rst       = 1'b1;
        lbus_wrn  = 1'b0;
        lbus_rdn  = 1'b1;
        lbus_di_a = 16'h0000;
        busy_i    = 1'b0;
        done_i    = 1'b0;
        res_i     = '0;
        for (int k = 0; k < NWORD; k++) exp_coef[k] = 32'h0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk16("reset_lbus_do", lbus_do, 16'h0000);
        chk16("reset_start_o", {15'b0, start_o}, 16'h0000);
        chk_coef("reset_coef");
        @(negedge clk);
        rst = 1'b0;

        // Full load of all coefficient halves
        for (int k = 0; k < NWORD; k++) begin
            base = (k < NWORD - 1) ? 16'(16'h0100 + 2*k) : 16'h0110;
            wr(base, 16'(k));
            wr(base + 16'd1, 16'h0001);
            exp_coef[k] = 32'h0001_0000 + 32'(k);
        end
        chk_coef("full_load");
        rd(16'h010A, 16'h0005, "rd_coef5_lo");
        rd(16'h0111, 16'h0001, "rd_coef6_hi");
        rd(16'h0110, 16'h0006, "rd_coef6_lo");

        // Start accepted when idle, dropped when busy
        push_start("start_idle");
        wr(16'h0002, 16'h0001);
        cyc(1'b0, 1'b1, 16'h0000, 1'b0);
        busy_i = 1'b1;
        wr(16'h0002, 16'h0001);
        cyc(1'b0, 1'b1, 16'h0000, 1'b0);
        busy_i = 1'b0;

        // Status after a done pulse
        cyc(1'b0, 1'b1, 16'h0000, 1'b1);
        rd(16'h0002, 16'h0002, "rd_status_done");
        busy_i = 1'b1;
        rd(16'h0002, 16'h0003, "rd_status_done_busy");
        busy_i = 1'b0;

        // Result readback and unmapped holes
        res_i[32*3 +: 32] = 32'hDEAD_BEEF;
        res_i[32*6 +: 32] = 32'hCAFE_1234;
        res_i[32*0 +: 32] = 32'h1111_2222;
        rd(16'h0186, 16'hBEEF, "rd_res3_lo");
        rd(16'h0187, 16'hDEAD, "rd_res3_hi");
        rd(16'h018D, 16'hCAFE, "rd_res6_hi");
        rd(16'h018E, 16'h0000, "rd_past_res");
        rd(16'h0150, 16'h0000, "rd_unmapped");
        rd(16'h010C, 16'h0000, "rd_coef_gap");

        // Start and done in the same cycle: done wins
        push_start("start_with_done");
        cyc(1'b1, 1'b1, 16'h0002, 1'b0);
        cyc(1'b0, 1'b1, 16'h0001, 1'b1);
        rd(16'h0002, 16'h0002, "rd_done_wins");
        push_start("start_clears_done");
        wr(16'h0002, 16'h0001);
        rd(16'h0002, 16'h0000, "rd_done_cleared");

        // Back-to-back start writes
        push_start("start_b2b_a");
        push_start("start_b2b_b");
        wr(16'h0002, 16'h0001);
        wr(16'h0002, 16'h0001);

        // Double address cycle: last address wins
        cyc(1'b1, 1'b1, 16'h0100, 1'b0);
        wr(16'h0101, 16'h1234);
        exp_coef[0] = 32'h1234_0000;
        chk_coef("double_addr");

        // Orphan data cycle, writes to read-only / unmapped
        cyc(1'b0, 1'b1, 16'hFFFF, 1'b0);
        chk_coef("orphan_data");
        wr(16'h0180, 16'h5555);
        rd(16'h0180, 16'h2222, "rd_res0_after_wr");
        wr(16'h0112, 16'h7777);
        chk_coef("write_ignored");

        // Soft clear, then clear combined with start
        wr(16'h0002, 16'h0004);
        for (int k = 0; k < NWORD; k++) exp_coef[k] = 32'h0;
        chk_coef("soft_clear");
        wr(16'h0104, 16'h00AA);
        exp_coef[2] = 32'h0000_00AA;
        chk_coef("reload_word2");
        push_start("start_with_clear");
        wr(16'h0002, 16'h0005);
        exp_coef[2] = 32'h0;
        chk_coef("clear_and_start");

        // Reset between address and data cycle
        rd(16'h0186, 16'hBEEF, "rd_before_rst");
        cyc(1'b1, 1'b1, 16'h0102, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        lbus_wrn = 1'b0;
        lbus_rdn = 1'b1;
        @(posedge clk);
        #1;
        chk16("rst_mid_lbus_do", lbus_do, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b1, 16'hABCD, 1'b0);
        chk_coef("rst_mid_no_write");

        repeat (3) cyc(1'b0, 1'b1, 16'h0000, 1'b0);

        checks++;
        if (seen_starts != exp_starts) begin
            failures++;
            $display("FAIL start_count: got %0d pulses, required %0d", seen_starts, exp_starts);
        end
        checks++;
        if (q_kind.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0 (next %s)",
                     q_kind.size(), q_name[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lbus_poly_if.md
# lbus_poly_if

Local-bus slave for the polynomial-core SASEBO-GIII chip top: the receiving end of the host's address/data write sequence. Decodes the two-cycle local-bus transfer (address cycle, then data cycle) into a register file holding seven 32-bit coefficient words. Issues a one-cycle start pulse to the polynomial core and serves read-back of status and result words on `lbus_do`.

## Interface
- `NWORD`, 7: number of 32-bit coefficient/result words.
- `ADDR_CTRL`, 16'h0002: control/status register address.
- `ADDR_COEF`, 16'h0100: base of coefficient words 0..NWORD-2. Word k low half is at base+2k, high half at base+2k+1.
- `ADDR_COEF_LAST`, 16'h0110: low-half address of the last coefficient word; high half is at +1.
- `ADDR_RES`, 16'h0180: base of result words 0..NWORD-1. Word k low half is at base+2k, high half at base+2k+1; read-only.
- `clk`  in  1  single clock; the local-bus clock domain. Everything samples on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `lbus_di_a`  in  16  address in the address cycle, data in the data cycle.
- `lbus_wrn`  in  1  high marks an address cycle; low in the following cycle marks the data cycle.
- `lbus_rdn`  in  1  low in the cycle after an address cycle requests a read.
- `lbus_do`  out  16  registered read data.
- `coef_o`  out  32*NWORD  coefficient words; word k is at [32k+31:32k].
- `start_o`  out  1  one-cycle start pulse to the core.
- `busy_i`  in  1  core is busy.
- `done_i`  in  1  one-cycle completion pulse from the core.
- `res_i`  in  32*NWORD  result words from the core; same packing as `coef_o`.

## Operation
- FSM with two states: S_IDLE and S_ADDR.
- `lbus_wrn`=1, any state:
  - latch `lbus_di_a` into `addr_q`;
  - go to S_ADDR.
  - A second consecutive address cycle overrides the first.
- S_ADDR, `lbus_wrn`=0, `lbus_rdn`=1: write commit with data `lbus_di_a` to `addr_q`, then go to S_IDLE.
- S_ADDR, `lbus_wrn`=0, `lbus_rdn`=0: read of `addr_q`; `lbus_do` is loaded, then go to S_IDLE. A read takes priority over a write.
- S_IDLE, `lbus_wrn`=0: no action. Data cycles without a preceding address cycle are ignored.
- Write map:
  - Coefficient half-word addresses update only the addressed 16 bits.
  - CTRL write, bit0=1 and `busy_i`=0: `start_o` pulses, and `done_flag` is cleared.
  - CTRL write, bit0=1 and `busy_i`=1: ignored; no pulse.
  - CTRL write, bit2=1: all coefficient words are cleared to 0. If bit0 is also set, the clear applies and the start pulse still fires.
  - Writes to any other address, including result addresses, are ignored.
- Read map:
  - CTRL returns {14'b0, `done_flag`, `busy_i`}.
  - Coefficient addresses return the stored half-word.
  - Result addresses return the `res_i` half-word.
  - Unmapped addresses return 16'h0000.
- `done_flag`:
  - set on `done_i`=1;
  - cleared on an accepted start;
  - if both occur in the same cycle, the set wins.
- Address compare is on the full 16 bits; no aliasing.

## Timing
- Reset values: state S_IDLE, `addr_q`=0, all coefficient words 0, `lbus_do`=16'h0000, `start_o`=0, `done_flag`=0.
- Reset mid-transaction discards the latched address; the next data cycle is ignored.
- Write latency: for a data cycle sampled at edge N, `coef_o` shows the new value from edge N. `start_o` is high for exactly one cycle, from edge N to edge N+1.
- Read latency: for an `lbus_rdn`=0 data cycle sampled at edge N, `lbus_do` is valid from edge N. It holds until the next read or reset.
- Back-to-back transfers: an address cycle may directly follow a data cycle. Minimum 2 cycles per transfer, no wait states.
- `start_o` is never high two cycles in a row, even with back-to-back start writes: a second CTRL write needs at least 2 cycles and, by then, the core asserts `busy_i` or not as it decides.

## Test plan
- Reset then idle: hold `rst`=1 for 2 cycles -> every output is 0 and `coef_o`=0.
- Full load: 14 address/data pairs writing halves of 0x00010000..0x00010006 to 0x100..0x10B and 0x110/0x111 -> `coef_o` word k = 0x00010000+k. No `start_o` pulses.
- Start: addr 0x002, data 0x0001, with `busy_i`=0 -> `start_o`=1 for exactly one cycle, at the data-cycle edge. Repeat with `busy_i`=1 -> no pulse.
- Status/result readback:
  - Pulse `done_i`, then read 0x002 -> `lbus_do`=16'h0002.
  - With `res_i` word 3 = 0xDEADBEEF, read 0x186 -> 16'hBEEF; read 0x187 -> 16'hDEAD.
  - Read 0x150 -> 16'h0000.
- Protocol corners:
  - Two address cycles 0x100 then 0x101, then data 0x1234 -> only the high half of word 0 changes.
  - Data cycle with no address cycle -> no change.
  - Write to 0x180 -> ignored.
- Soft clear and reset mid-transfer:
  - CTRL data 0x0004 -> `coef_o`=0.
  - Assert `rst` between an address cycle and its data cycle -> the data is not written.
